// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: opcodes, FSM states and the flag bundle shared by the
// sequential ALU and its single-cycle datapath.
package alu_seq_pkg;

    localparam logic [4:0] OP_NOP   = 5'b00000;
    localparam logic [4:0] OP_ADD   = 5'b00001;
    localparam logic [4:0] OP_AND   = 5'b00010;
    localparam logic [4:0] OP_SUB   = 5'b00011;
    localparam logic [4:0] OP_OR    = 5'b00100;
    localparam logic [4:0] OP_XOR   = 5'b00101;
    localparam logic [4:0] OP_MOV   = 5'b00110;
    localparam logic [4:0] OP_ADC   = 5'b00111;
    localparam logic [4:0] OP_NOT   = 5'b01000;
    localparam logic [4:0] OP_SAR   = 5'b01001;
    localparam logic [4:0] OP_SLR   = 5'b01010;
    localparam logic [4:0] OP_SAL   = 5'b01011;
    localparam logic [4:0] OP_SLL   = 5'b01100;
    localparam logic [4:0] OP_ROL   = 5'b01101;
    localparam logic [4:0] OP_ROR   = 5'b01110;
    localparam logic [4:0] OP_MUL   = 5'b01111;
    localparam logic [4:0] OP_SHOWR = 5'b11111;

    typedef enum logic [1:0] {IDLE, SHIFT, MUL} state_t;

    typedef struct packed {
        logic cf;
        logic zf;
        logic sf;
        logic of;
    } flags_t;

    // Dense opcode block 0..15 plus SHOWR; everything else traps.
    function automatic logic is_legal(input logic [4:0] op);
        return (op <= OP_MUL) || (op == OP_SHOWR);
    endfunction

    function automatic logic is_shift(input logic [4:0] op);
        return (op >= OP_SAR) && (op <= OP_ROR);
    endfunction

endpackage

// File: rtl/alu_seq_core.sv
// alu_seq_core: single-cycle datapath (add/adc/sub/logic/mov/not/showr)
// with flag generation. Shifts, MUL and illegal ops are handled by the top.
module alu_seq_core
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [4:0]       op,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  flags_t           flags_in,
    output logic [WIDTH-1:0] res,
    output logic             res_we,
    output flags_t           flags_out
);
    localparam int MSB = WIDTH - 1;

    logic [WIDTH:0] sum;
    logic           flag_we;

    // Result mux plus flags; arithmetic done one bit wider to expose carry/borrow.
    always_comb begin
        sum       = '0;
        res       = '0;
        res_we    = 1'b1;
        flag_we   = 1'b1;
        flags_out = flags_in;
        case (op)
            OP_ADD, OP_ADC: begin
                sum = {1'b0, in1} + {1'b0, in2}
                    + {{WIDTH{1'b0}}, (op == OP_ADC) & flags_in.cf};
                res = sum[MSB:0];
                flags_out.cf = sum[WIDTH];
                flags_out.of = (in1[MSB] == in2[MSB]) && (res[MSB] != in1[MSB]);
            end
            OP_SUB: begin
                sum = {1'b0, in1} - {1'b0, in2};
                res = sum[MSB:0];
                flags_out.cf = sum[WIDTH];
                flags_out.of = (in1[MSB] != in2[MSB]) && (res[MSB] != in1[MSB]);
            end
            OP_AND, OP_OR, OP_XOR: begin
                res = (op == OP_AND) ? (in1 & in2) :
                      (op == OP_OR)  ? (in1 | in2) : (in1 ^ in2);
                flags_out.cf = 1'b0;
                flags_out.of = 1'b0;
            end
            OP_MOV: begin
                res     = in2;
                flag_we = 1'b0;
            end
            OP_NOT: begin
                res     = ~in1;
                flag_we = 1'b0;
            end
            OP_SHOWR: begin
                res     = in1;
                flag_we = 1'b0;
            end
            default: begin
                // NOP keeps res; shift/MUL/illegal never reach here as writers.
                res_we  = 1'b0;
                flag_we = 1'b0;
            end
        endcase
        if (flag_we) begin
            flags_out.zf = (res == '0);
            flags_out.sf = res[MSB];
        end
    end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: sequential ALU with valid/ready issue, architectural flag
// registers, bit-serial shifts/rotates and a shift-add unsigned multiply.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       op,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [SHW-1:0]   im,
    output logic             out_valid,
    output logic             out_err,
    output logic [WIDTH-1:0] res,
    output logic [WIDTH-1:0] res_hi,
    output logic             CF,
    output logic             ZF,
    output logic             SF,
    output logic             OF
);
    localparam int MSB = WIDTH - 1;

    state_t           state;
    flags_t           flags;
    logic [4:0]       op_q;
    logic             orig_msb;
    logic [WIDTH-1:0] sh;
    logic [SHW-1:0]   cnt;
    logic [WIDTH-1:0] mcand, p_hi, p_lo;

    logic [WIDTH-1:0] core_res;
    logic             core_res_we;
    flags_t           core_flags;

    logic [WIDTH-1:0] sh_next;
    logic             sh_out, sh_of;

    logic [WIDTH-1:0] m_hi, m_lo, m_mc, m_nhi, m_nlo;
    logic [WIDTH:0]   m_add;

    alu_seq_core #(.WIDTH(WIDTH)) u_core (
        .op        (op),
        .in1       (in1),
        .in2       (in2),
        .flags_in  (flags),
        .res       (core_res),
        .res_we    (core_res_we),
        .flags_out (core_flags)
    );

    assign in_ready = (state == IDLE);
    assign CF = flags.cf;
    assign ZF = flags.zf;
    assign SF = flags.sf;
    assign OF = flags.of;

    // One shift/rotate step on the working register; sh_out is the bit leaving it.
    always_comb begin
        sh_next = sh;
        sh_out  = 1'b0;
        case (op_q)
            OP_SAR: begin sh_next = {sh[MSB], sh[MSB:1]};   sh_out = sh[0];   end
            OP_SLR: begin sh_next = {1'b0, sh[MSB:1]};      sh_out = sh[0];   end
            OP_SAL,
            OP_SLL: begin sh_next = {sh[MSB-1:0], 1'b0};    sh_out = sh[MSB]; end
            OP_ROL: begin sh_next = {sh[MSB-1:0], sh[MSB]}; sh_out = sh[MSB]; end
            OP_ROR: begin sh_next = {sh[0], sh[MSB:1]};     sh_out = sh[0];   end
            default: ;
        endcase
        case (op_q)
            OP_SAR:  sh_of = 1'b0;
            OP_SLR:  sh_of = orig_msb;
            default: sh_of = sh_next[MSB] ^ orig_msb;
        endcase
    end

    // One shift-add multiply step; in IDLE it runs on the raw operands so the
    // first iteration lands on the acceptance edge.
    always_comb begin
        m_hi  = (state == MUL) ? p_hi  : '0;
        m_lo  = (state == MUL) ? p_lo  : in2;
        m_mc  = (state == MUL) ? mcand : in1;
        m_add = {1'b0, m_hi} + (m_lo[0] ? {1'b0, m_mc} : {(WIDTH+1){1'b0}});
        m_nhi = m_add[WIDTH:1];
        m_nlo = {m_add[0], m_lo[MSB:1]};
    end

    // Issue/iterate FSM; result, flags and the completion pulse are written together.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            flags     <= '0;
            res       <= '0;
            res_hi    <= '0;
            out_valid <= 1'b0;
            out_err   <= 1'b0;
            op_q      <= OP_NOP;
            orig_msb  <= 1'b0;
            sh        <= '0;
            cnt       <= '0;
            mcand     <= '0;
            p_hi      <= '0;
            p_lo      <= '0;
        end else begin
            out_valid <= 1'b0;
            out_err   <= 1'b0;
            case (state)
                IDLE: if (in_valid) begin
                    op_q     <= op;
                    orig_msb <= in1[MSB];
                    if (!is_legal(op)) begin
                        out_valid <= 1'b1;
                        out_err   <= 1'b1;
                    end else if (is_shift(op)) begin
                        if (im == '0) begin
                            // Zero-length shift completes at once and keeps CF.
                            res       <= in1;
                            flags.zf  <= (in1 == '0);
                            flags.sf  <= in1[MSB];
                            flags.of  <= 1'b0;
                            out_valid <= 1'b1;
                        end else begin
                            sh    <= in1;
                            cnt   <= im;
                            state <= SHIFT;
                        end
                    end else if (op == OP_MUL) begin
                        p_hi  <= m_nhi;
                        p_lo  <= m_nlo;
                        mcand <= in1;
                        cnt   <= SHW'(1);
                        state <= MUL;
                    end else begin
                        if (core_res_we) res <= core_res;
                        flags     <= core_flags;
                        out_valid <= 1'b1;
                    end
                end
                SHIFT: begin
                    sh <= sh_next;
                    if (cnt == SHW'(1)) begin
                        res       <= sh_next;
                        flags     <= '{cf: sh_out, zf: (sh_next == '0),
                                       sf: sh_next[MSB], of: sh_of};
                        out_valid <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        cnt <= cnt - SHW'(1);
                    end
                end
                MUL: begin
                    p_hi <= m_nhi;
                    p_lo <= m_nlo;
                    if (cnt == SHW'(WIDTH - 1)) begin
                        res       <= m_nlo;
                        res_hi    <= m_nhi;
                        flags     <= '{cf: (m_nhi != '0), zf: ({m_nhi, m_nlo} == '0),
                                       sf: m_nhi[MSB], of: (m_nhi != '0)};
                        out_valid <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        cnt <= cnt + SHW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
